// File: rtl/cm0_dap_ap_arb.sv
// Two-master arbiter for the DAP AP slave bus. Master 0 (AP bus master) and
// master 1 (secondary debug requester) share one registered downstream slave
// port. A granted transfer stays locked until slvready completes it.
module cm0_dap_ap_arb #(
    parameter int PRIORITY = 0,
    parameter int MAXRUN   = 4
) (
    input  logic        dclk,
    input  logic        apreset_n,
    input  logic        arben,
    input  logic [1:0]  m0_trans,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_write,
    input  logic [1:0]  m0_size,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_resp,
    input  logic [1:0]  m1_trans,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_write,
    input  logic [1:0]  m1_size,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_resp,
    output logic [31:0] slvaddr,
    output logic [31:0] slvwdata,
    output logic        slvwrite,
    output logic [1:0]  slvsize,
    output logic [1:0]  slvtrans,
    input  logic [31:0] slvrdata,
    input  logic        slvready,
    input  logic        slvresp,
    output logic        arb_grant,
    output logic        arb_busy
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic       FIXED_PRIO = (PRIORITY != 0);
    localparam logic [3:0] RUN_MAX    = 4'(MAXRUN);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       last_nxt;
    logic [3:0] run_cnt;
    logic [3:0] run_nxt;
    logic       req0;
    logic       req1;
    logic       pref;
    logic       win;
    logic       start;

    assign req0 = (m0_trans == 2'b10);
    assign req1 = (m1_trans == 2'b10);

    // Winner selection, run-length accounting and next-state decode
    always_comb begin
        state_nxt = state;
        last_nxt  = last_grant;
        run_nxt   = run_cnt;
        start     = 1'b0;
        pref      = FIXED_PRIO ? 1'b0 : ~last_grant;
        win       = req1;
        if (req0 && req1) begin
            win = pref;
            // A master that has hit the run limit yields to the waiting one
            if ((run_cnt == RUN_MAX) && (pref == last_grant)) begin
                win = ~pref;
            end
        end
        case (state)
            IDLE: begin
                if (arben && (req0 || req1)) begin
                    start     = 1'b1;
                    state_nxt = BUSY;
                    last_nxt  = win;
                    if (req0 && req1 && (win == last_grant)) begin
                        run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 4'd1;
                    end else begin
                        run_nxt = 4'd1;
                    end
                end
            end
            BUSY: begin
                if (slvready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, grant history, run count and status flags
    always_ff @(posedge dclk or negedge apreset_n) begin
        if (!apreset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            run_cnt    <= 4'd0;
            arb_busy   <= 1'b0;
            arb_grant  <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_nxt;
            run_cnt    <= run_nxt;
            arb_busy   <= (state_nxt == BUSY);
            if (start) begin
                arb_grant <= win;
            end
        end
    end

    // Downstream request register: loaded on grant, trans cleared on completion
    always_ff @(posedge dclk or negedge apreset_n) begin
        if (!apreset_n) begin
            slvaddr  <= 32'd0;
            slvwdata <= 32'd0;
            slvwrite <= 1'b0;
            slvsize  <= 2'b00;
            slvtrans <= 2'b00;
        end else if (start) begin
            slvaddr  <= win ? m1_addr  : m0_addr;
            slvwdata <= win ? m1_wdata : m0_wdata;
            slvwrite <= win ? m1_write : m0_write;
            slvsize  <= win ? m1_size  : m0_size;
            slvtrans <= 2'b10;
        end else if ((state == BUSY) && slvready) begin
            slvtrans <= 2'b00;
        end
    end

    // Response routing back to the owning master is purely combinational
    always_comb begin
        m0_ready = slvready & arb_busy & ~arb_grant;
        m1_ready = slvready & arb_busy &  arb_grant;
        m0_rdata = (arb_busy & ~arb_grant) ? slvrdata : 32'd0;
        m1_rdata = (arb_busy &  arb_grant) ? slvrdata : 32'd0;
        m0_resp  = slvresp & arb_busy & ~arb_grant;
        m1_resp  = slvresp & arb_busy &  arb_grant;
    end

endmodule

// File: tb/tb_cm0_dap_ap_arb.sv
// Directed testbench for cm0_dap_ap_arb: a round-robin instance (dut) and a
// fixed-priority instance (fp) share all inputs and are checked separately.
module tb_cm0_dap_ap_arb;

    logic        dclk;
    logic        apreset_n;
    logic        arben;
    logic [1:0]  m0_trans, m1_trans;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_write, m1_write;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] slvrdata;
    logic        slvready, slvresp;

    logic        m0_ready, m1_ready, m0_resp, m1_resp;
    logic [31:0] m0_rdata, m1_rdata, slvaddr, slvwdata;
    logic        slvwrite, arb_grant, arb_busy;
    logic [1:0]  slvsize, slvtrans;

    logic        fp_m0_ready, fp_m1_ready, fp_m0_resp, fp_m1_resp;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_slvaddr, fp_slvwdata;
    logic        fp_slvwrite, fp_arb_grant, fp_arb_busy;
    logic [1:0]  fp_slvsize, fp_slvtrans;

    int checks = 0;
    int failures = 0;

    cm0_dap_ap_arb #(.PRIORITY(0), .MAXRUN(4)) dut (
        .dclk(dclk), .apreset_n(apreset_n), .arben(arben),
        .m0_trans(m0_trans), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_write(m0_write), .m0_size(m0_size), .m0_ready(m0_ready),
        .m0_rdata(m0_rdata), .m0_resp(m0_resp),
        .m1_trans(m1_trans), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_write(m1_write), .m1_size(m1_size), .m1_ready(m1_ready),
        .m1_rdata(m1_rdata), .m1_resp(m1_resp),
        .slvaddr(slvaddr), .slvwdata(slvwdata), .slvwrite(slvwrite),
        .slvsize(slvsize), .slvtrans(slvtrans), .slvrdata(slvrdata),
        .slvready(slvready), .slvresp(slvresp),
        .arb_grant(arb_grant), .arb_busy(arb_busy)
    );

    cm0_dap_ap_arb #(.PRIORITY(1), .MAXRUN(4)) fp (
        .dclk(dclk), .apreset_n(apreset_n), .arben(arben),
        .m0_trans(m0_trans), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_write(m0_write), .m0_size(m0_size), .m0_ready(fp_m0_ready),
        .m0_rdata(fp_m0_rdata), .m0_resp(fp_m0_resp),
        .m1_trans(m1_trans), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_write(m1_write), .m1_size(m1_size), .m1_ready(fp_m1_ready),
        .m1_rdata(fp_m1_rdata), .m1_resp(fp_m1_resp),
        .slvaddr(fp_slvaddr), .slvwdata(fp_slvwdata), .slvwrite(fp_slvwrite),
        .slvsize(fp_slvsize), .slvtrans(fp_slvtrans), .slvrdata(slvrdata),
        .slvready(slvready), .slvresp(slvresp),
        .arb_grant(fp_arb_grant), .arb_busy(fp_arb_busy)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic idle_inputs();
        arben    = 1'b1;
        m0_trans = 2'b00; m0_addr = 32'd0; m0_wdata = 32'd0; m0_write = 1'b0; m0_size = 2'b00;
        m1_trans = 2'b00; m1_addr = 32'd0; m1_wdata = 32'd0; m1_write = 1'b0; m1_size = 2'b00;
        slvrdata = 32'd0; slvready = 1'b0; slvresp = 1'b0;
    endtask

    // Pulse reset between clock edges
    task automatic do_reset();
        apreset_n = 1'b0;
        #3;
        apreset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        apreset_n = 1'b0;
        slvrdata  = 32'hFFFF_FFFF;
        slvready  = 1'b1;
        slvresp   = 1'b1;
        #2;
        checks++;
        if (slvtrans !== 2'b00 || slvaddr !== 32'd0 || slvwdata !== 32'd0 || slvwrite !== 1'b0 || slvsize !== 2'b00) begin
            failures++;
            $display("FAIL reset_slv: trans=%b addr=%h wdata=%h write=%b size=%b, required all zero",
                     slvtrans, slvaddr, slvwdata, slvwrite, slvsize);
        end
        checks++;
        if (arb_busy !== 1'b0 || arb_grant !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: busy=%b grant=%b, required 0 0", arb_busy, arb_grant);
        end
        checks++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || m0_rdata !== 32'd0 || m1_resp !== 1'b0) begin
            failures++;
            $display("FAIL reset_master: m0_ready=%b m1_ready=%b m0_rdata=%h m1_resp=%b, required zero",
                     m0_ready, m1_ready, m0_rdata, m1_resp);
        end
        idle_inputs();
        tick();
        apreset_n = 1'b1;
        tick();
        checks++;
        if (slvtrans !== 2'b00 || arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: trans=%b busy=%b, required 00 0", slvtrans, arb_busy);
        end
    endtask

    task automatic test_single_write();
        m0_trans = 2'b10; m0_addr = 32'hE000_ED00; m0_wdata = 32'h1234_5678;
        m0_write = 1'b1; m0_size = 2'b10;
        tick();
        checks++;
        if (slvtrans !== 2'b10 || slvaddr !== 32'hE000_ED00 || slvwdata !== 32'h1234_5678 ||
            slvwrite !== 1'b1 || slvsize !== 2'b10) begin
            failures++;
            $display("FAIL write_issue: trans=%b addr=%h wdata=%h write=%b size=%b, required 10 e000ed00 12345678 1 10",
                     slvtrans, slvaddr, slvwdata, slvwrite, slvsize);
        end
        checks++;
        if (arb_busy !== 1'b1 || arb_grant !== 1'b0 || m0_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_busy: busy=%b grant=%b m0_ready=%b, required 1 0 0", arb_busy, arb_grant, m0_ready);
        end
        tick();
        checks++;
        if (slvtrans !== 2'b10 || slvaddr !== 32'hE000_ED00 || slvwdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL write_hold2: trans=%b addr=%h wdata=%h, required stable", slvtrans, slvaddr, slvwdata);
        end
        tick();
        slvready = 1'b1;
        #1;
        checks++;
        if (slvtrans !== 2'b10 || slvaddr !== 32'hE000_ED00 || m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_ready: trans=%b addr=%h m0_ready=%b m1_ready=%b, required 10 e000ed00 1 0",
                     slvtrans, slvaddr, m0_ready, m1_ready);
        end
        tick();
        m0_trans = 2'b00;
        slvready = 1'b0;
        #1;
        checks++;
        if (slvtrans !== 2'b00 || slvaddr !== 32'hE000_ED00 || slvwdata !== 32'h1234_5678 ||
            arb_busy !== 1'b0 || m0_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_done: trans=%b addr=%h wdata=%h busy=%b m0_ready=%b, required 00 e000ed00 12345678 0 0",
                     slvtrans, slvaddr, slvwdata, arb_busy, m0_ready);
        end
    endtask

    task automatic test_round_robin();
        idle_inputs();
        do_reset();
        m0_trans = 2'b10; m0_addr = 32'h0000_0100;
        m1_trans = 2'b10; m1_addr = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            logic        eg;
            logic [31:0] rd;
            eg = 1'(i % 2);
            rd = 32'hCAFE_0000 + 32'(i);
            tick();
            checks++;
            if (arb_grant !== eg || arb_busy !== 1'b1 || slvaddr !== (eg ? 32'h200 : 32'h100)) begin
                failures++;
                $display("FAIL rr_grant[%0d]: grant=%b busy=%b addr=%h, required %b 1 %h",
                         i, arb_grant, arb_busy, slvaddr, eg, (eg ? 32'h200 : 32'h100));
            end
            slvready = 1'b1;
            slvrdata = rd;
            #1;
            checks++;
            if (m1_rdata !== (eg ? rd : 32'd0) || m0_rdata !== (eg ? 32'd0 : rd) ||
                m1_ready !== eg || m0_ready !== ~eg) begin
                failures++;
                $display("FAIL rr_resp[%0d]: m0_rdata=%h m1_rdata=%h m0_ready=%b m1_ready=%b, required grant %b data %h",
                         i, m0_rdata, m1_rdata, m0_ready, m1_ready, eg, rd);
            end
            tick();
            slvready = 1'b0;
            slvrdata = 32'd0;
        end
        idle_inputs();
    endtask

    task automatic test_fixed_priority();
        logic exp_g [10];
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        idle_inputs();
        do_reset();
        m0_trans = 2'b10; m0_addr = 32'h0000_0100;
        m1_trans = 2'b10; m1_addr = 32'h0000_0200;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (fp_arb_grant !== exp_g[i] || fp_arb_busy !== 1'b1 ||
                fp_slvaddr !== (exp_g[i] ? 32'h200 : 32'h100)) begin
                failures++;
                $display("FAIL fp_grant[%0d]: grant=%b busy=%b addr=%h, required %b 1",
                         i, fp_arb_grant, fp_arb_busy, fp_slvaddr, exp_g[i]);
            end
            slvready = 1'b1;
            tick();
            slvready = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_arben();
        idle_inputs();
        do_reset();
        m1_trans = 2'b10; m1_addr = 32'h0000_0A00;
        tick();
        checks++;
        if (arb_busy !== 1'b1 || arb_grant !== 1'b1 || slvaddr !== 32'h0000_0A00) begin
            failures++;
            $display("FAIL arben_m1_grant: busy=%b grant=%b addr=%h, required 1 1 00000a00", arb_busy, arb_grant, slvaddr);
        end
        arben    = 1'b0;
        m0_trans = 2'b10; m0_addr = 32'h0000_0B00;
        tick();
        slvready = 1'b1;
        #1;
        checks++;
        if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin
            failures++;
            $display("FAIL arben_m1_done: m1_ready=%b m0_ready=%b, required 1 0", m1_ready, m0_ready);
        end
        tick();
        m1_trans = 2'b00;
        slvready = 1'b0;
        tick();
        tick();
        checks++;
        if (arb_busy !== 1'b0 || slvtrans !== 2'b00) begin
            failures++;
            $display("FAIL arben_hold: busy=%b trans=%b, required 0 00", arb_busy, slvtrans);
        end
        arben = 1'b1;
        tick();
        checks++;
        if (arb_busy !== 1'b1 || arb_grant !== 1'b0 || slvaddr !== 32'h0000_0B00 || slvtrans !== 2'b10) begin
            failures++;
            $display("FAIL arben_m0_grant: busy=%b grant=%b addr=%h trans=%b, required 1 0 00000b00 10",
                     arb_busy, arb_grant, slvaddr, slvtrans);
        end
        slvready = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_error_resp();
        idle_inputs();
        m0_trans = 2'b10; m0_addr = 32'h4000_0010; m0_write = 1'b0; m0_size = 2'b01;
        tick();
        checks++;
        if (arb_busy !== 1'b1 || arb_grant !== 1'b0 || slvwrite !== 1'b0 || slvsize !== 2'b01) begin
            failures++;
            $display("FAIL err_issue: busy=%b grant=%b write=%b size=%b, required 1 0 0 01",
                     arb_busy, arb_grant, slvwrite, slvsize);
        end
        slvready = 1'b1;
        slvresp  = 1'b1;
        slvrdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (m0_resp !== 1'b1 || m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m1_resp !== 1'b0) begin
            failures++;
            $display("FAIL err_resp: m0_resp=%b m0_ready=%b m0_rdata=%h m1_resp=%b, required 1 1 deadbeef 0",
                     m0_resp, m0_ready, m0_rdata, m1_resp);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (arb_busy !== 1'b0 || slvtrans !== 2'b00 || m0_resp !== 1'b0) begin
            failures++;
            $display("FAIL err_idle: busy=%b trans=%b m0_resp=%b, required 0 00 0", arb_busy, slvtrans, m0_resp);
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        m1_trans = 2'b10; m1_addr = 32'h0000_0300; m1_wdata = 32'h5555_AAAA; m1_write = 1'b1;
        tick();
        checks++;
        if (arb_busy !== 1'b1 || arb_grant !== 1'b1) begin
            failures++;
            $display("FAIL ares_pre: busy=%b grant=%b, required 1 1", arb_busy, arb_grant);
        end
        slvready = 1'b1;
        #1;
        apreset_n = 1'b0;
        #1;
        checks++;
        if (slvtrans !== 2'b00 || slvaddr !== 32'd0 || slvwdata !== 32'd0 || arb_busy !== 1'b0 ||
            arb_grant !== 1'b0 || m1_ready !== 1'b0) begin
            failures++;
            $display("FAIL ares_clear: trans=%b addr=%h wdata=%h busy=%b grant=%b m1_ready=%b, required all zero",
                     slvtrans, slvaddr, slvwdata, arb_busy, arb_grant, m1_ready);
        end
        slvready  = 1'b0;
        #1;
        apreset_n = 1'b1;
        tick();
        checks++;
        if (arb_busy !== 1'b1 || arb_grant !== 1'b1 || slvaddr !== 32'h0000_0300 || slvtrans !== 2'b10) begin
            failures++;
            $display("FAIL ares_regrant: busy=%b grant=%b addr=%h trans=%b, required 1 1 00000300 10",
                     arb_busy, arb_grant, slvaddr, slvtrans);
        end
        slvready = 1'b1;
        tick();
        idle_inputs();
    endtask

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apreset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_fixed_priority();
        test_arben();
        test_error_resp();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
